serial_tx_shifter: RTL and testbench

SERIAL_TX_SHIFTER -- requirements
Module: serial_tx_shifter

---
 rtl/serial_tx_shifter.sv | 118 +++++++++++
 tb/tb_serial_tx_shifter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_shifter.sv
// Parallel-to-serial frame transmitter: start bit, WIDTH data bits, stop bit, each CLKS_PER_BIT cycles.
// One-cycle accept into START; ready only while idle, so valid is held off for the whole frame.
module serial_tx_shifter #(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 1,
  parameter int MSB_FIRST    = 0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] p,
  input  logic             valid,
  output logic             ready,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(WIDTH);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]        state;
  logic [WIDTH-1:0]  shreg;
  logic [WIDTH-1:0]  shifted;
  logic [BIT_W-1:0]  bit_cnt;
  logic [BAUD_W-1:0] baud_cnt;
  logic              bit_end;
  logic              take;
  logic              first_bit;
  logic              next_bit;

  assign ready   = (state == IDLE) && !clear;
  assign take    = valid && ready;
  assign busy    = (state != IDLE);
  assign bit_end = (baud_cnt == BAUD_LAST);

  // The line bit is registered one step ahead: we load the bit that the next DATA slot presents.
  always_comb begin
    if (MSB_FIRST != 0) begin
      shifted   = {shreg[WIDTH-2:0], 1'b0};
      first_bit = shreg[WIDTH-1];
      next_bit  = shreg[WIDTH-2];
    end else begin
      shifted   = {1'b0, shreg[WIDTH-1:1]};
      first_bit = shreg[0];
      next_bit  = shreg[1];
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state    <= IDLE;
      sout     <= 1'b1;
      done     <= 1'b0;
      shreg    <= '0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            shreg    <= p;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            sout     <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            sout     <= first_bit;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              sout  <= 1'b1;
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= shifted;
              sout    <= next_bit;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            done     <= 1'b1;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          sout  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_shifter.sv
// Two configurations (LSB-first/1 clk per bit, MSB-first/3 clks per bit) driven with directed and random
// traffic; a frame-level model predicts handshake and line waveform, a monitor scores each finished frame.
module tb_serial_tx_shifter;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] word;
    int           len;
  } frame_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int CPB  = (g == 0) ? 1 : 3;
    localparam int MSBF = g;
    localparam int FLEN = (W + 2) * CPB;

    logic         clear = 1'b1;
    logic         valid = 1'b1;
    logic [W-1:0] p = 4'b1010;
    logic         ready, sout, busy, done;

    frame_t exp_q[$];
    logic   samples[$];
    int     remaining = 0;
    logic   done_exp = 1'b0;
    logic   accepted = 1'b0;
    logic   armed = 1'b0;
    logic   fin = 1'b0;

    serial_tx_shifter #(
      .WIDTH(W),
      .CLKS_PER_BIT(CPB),
      .MSB_FIRST(MSBF)
    ) dut (
      .clk(clk),
      .clear(clear),
      .p(p),
      .valid(valid),
      .ready(ready),
      .sout(sout),
      .busy(busy),
      .done(done)
    );

    // Expected line level for cycle i of a frame carrying w.
    function automatic logic wave(input logic [W-1:0] w, input int i);
      int slot;
      slot = i / CPB;
      if (slot == 0) return 1'b0;
      if (slot > W) return 1'b1;
      return (MSBF != 0) ? w[W - slot] : w[slot - 1];
    endfunction

    // Drive one cycle, then advance the frame model across the rising edge.
    task automatic cycle(input logic c, input logic v, input logic [W-1:0] d);
      clear = c;
      valid = v;
      p     = d;
      @(posedge clk);
      accepted = 1'b0;
      done_exp = 1'b0;
      if (c) begin
        if (remaining > 0 && exp_q.size() > 0)
          exp_q[exp_q.size()-1].len = FLEN - remaining + 1;
        remaining = 0;
      end else if (remaining > 0) begin
        remaining--;
        done_exp = (remaining == 0);
      end else if (v) begin
        remaining = FLEN;
        exp_q.push_back('{word: d, len: FLEN});
        accepted = 1'b1;
      end
      #1;
    endtask

    task automatic send(input logic [W-1:0] d);
      for (int n = 0; n < 200; n++) begin
        cycle(1'b0, 1'b1, d);
        if (accepted) break;
      end
    endtask

    task automatic idle_until_free();
      for (int n = 0; n < 200; n++) begin
        if (remaining == 0) break;
        cycle(1'b0, 1'b0, W'($urandom));
      end
    endtask

    initial begin
      int r;
      cycle(1'b1, 1'b1, 4'b1010);
      armed = 1'b1;
      cycle(1'b1, 1'b1, 4'b1010);
      cycle(1'b0, 1'b0, 4'b0000);

      send(4'b1010);
      idle_until_free();
      cycle(1'b0, 1'b0, 4'b0000);
      send(4'b1100);
      idle_until_free();

      // Back-to-back with valid never dropping; p changes while the first word is in flight.
      send(4'b0101);
      send(4'b0011);
      idle_until_free();
      cycle(1'b0, 1'b0, 4'b0000);

      // Abort in the first cycle of the second data bit.
      send(4'b0110);
      repeat (2 * CPB) cycle(1'b0, 1'b0, 4'b1001);
      cycle(1'b1, 1'b1, 4'b0111);
      send(4'b1111);
      idle_until_free();

      repeat (400) begin
        r = $urandom_range(0, 99);
        cycle(r < 2, r < 60, W'($urandom));
      end
      idle_until_free();
      repeat (3) cycle(1'b0, 1'b0, 4'b0000);
      chk($sformatf("cfg%0d_frames_outstanding", g), exp_q.size(), 0);
      fin = 1'b1;
    end

    initial begin
      frame_t       e;
      logic [W-1:0] q;
      logic         bitv;
      int           bad;
      forever begin
        @(negedge clk);
        if (armed) begin
          chk($sformatf("cfg%0d_ready", g), ready, (remaining == 0) && !clear);
          chk($sformatf("cfg%0d_busy", g), busy, remaining > 0);
          chk($sformatf("cfg%0d_done", g), done, done_exp);
          if (busy === 1'b1) begin
            samples.push_back(sout);
          end else begin
            chk($sformatf("cfg%0d_idle_sout", g), sout, 1'b1);
            if (samples.size() > 0) begin
              if (exp_q.size() == 0) begin
                chk($sformatf("cfg%0d_unexpected_frame_len", g), samples.size(), 0);
              end else begin
                e = exp_q.pop_front();
                chk($sformatf("cfg%0d_frame_len", g), samples.size(), e.len);
                bad = 0;
                for (int i = 0; i < samples.size() && i < e.len; i++)
                  if (samples[i] !== wave(e.word, i)) bad++;
                chk($sformatf("cfg%0d_frame_wave_errs word=%0h", g, e.word), bad, 0);
                if (e.len == FLEN && samples.size() == FLEN) begin
                  q = '0;
                  for (int k = 0; k < W; k++) begin
                    bitv = samples[(k + 1) * CPB + CPB / 2];
                    if (MSBF != 0) q = {q[W-2:0], bitv};
                    else           q = {bitv, q[W-1:1]};
                  end
                  chk($sformatf("cfg%0d_rx_word", g), q, e.word);
                end
              end
              samples.delete();
            end
          end
        end
      end
    end
  end

  initial begin
    for (int n = 0; n < 20000; n++) begin
      @(posedge clk);
      if (cfg[0].fin && cfg[1].fin) break;
    end
    chk("bench_completed", {cfg[0].fin, cfg[1].fin}, 2'b11);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
